// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - weight-matrix pass sequencer for the layer engine
//
// Drives the row-index counter strobes and the MAC accumulate enable for one
// full pass: 2 quadrants x 3 row pairs x VECTORS vectors x 2 rows x COLS
// cycles. The counter's row_index/new_layer feedback is checked against the
// schedule this block expects, and any disagreement latches seq_err.
//
// Ports:
//   clock            rising-edge clock
//   clear            synchronous active-high reset / abort
//   start            begin a pass (only honoured in IDLE)
//   row_index        counter feedback: current row
//   new_layer        counter feedback: quadrant wrap indication
//   ctr_en           counter enable (same as busy)
//   ctr_clear        counter clear strobe
//   new_row          counter strobe: advance one row
//   new_vector       counter strobe: back to the pair's first row
//   new_quadrant_row counter strobe: advance to the next row pair
//   quadrant_msb     counter base-quadrant select
//   mac_en           datapath accumulate enable
//   busy             pass in progress
//   done             one-cycle completion pulse
//   seq_err          sticky schedule-mismatch flag

module layer_sequencer #(
   parameter int COLS    = 4,
   parameter int VECTORS = 3
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       start,
   input  logic [3:0] row_index,
   input  logic       new_layer,
   output logic       ctr_en,
   output logic       ctr_clear,
   output logic       new_row,
   output logic       new_vector,
   output logic       new_quadrant_row,
   output logic       quadrant_msb,
   output logic       mac_en,
   output logic       busy,
   output logic       done,
   output logic       seq_err
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int VW = (VECTORS > 1) ? $clog2(VECTORS) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [VW-1:0] VEC_LAST = VW'(VECTORS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_ROW_A,
      S_ROW_B,
      S_RESTART,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col, col_nxt;
   logic [VW-1:0] vec, vec_nxt;
   logic [1:0]    pair, pair_nxt;
   logic          quad, quad_nxt;
   logic          seq_err_nxt;

   logic          col_last;
   logic          vec_last;
   logic          pair_last;
   logic          final_qr;
   logic          first_row_a;
   logic [3:0]    exp_row;

   assign col_last    = (col == COL_LAST);
   assign vec_last    = (vec == VEC_LAST);
   assign pair_last   = (pair == 2'd2);

   // Last cycle of the last pair in a quadrant: the counter wraps here and
   // must report new_layer in exactly this cycle.
   assign final_qr    = (state == S_ROW_B) && col_last && vec_last && pair_last;

   // col is zero on entry to ROW_A from every predecessor state.
   assign first_row_a = (state == S_ROW_A) && (col == '0);
   assign exp_row     = (quad ? 4'd6 : 4'd0) + {1'b0, pair, 1'b0};

   always_ff @(posedge clock) begin
      if (clear) begin
         state   <= S_IDLE;
         col     <= '0;
         vec     <= '0;
         pair    <= 2'd0;
         quad    <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         col     <= col_nxt;
         vec     <= vec_nxt;
         pair    <= pair_nxt;
         quad    <= quad_nxt;
         seq_err <= seq_err_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      col_nxt          = col;
      vec_nxt          = vec;
      pair_nxt         = pair;
      quad_nxt         = quad;
      ctr_clear        = 1'b0;
      new_row          = 1'b0;
      new_vector       = 1'b0;
      new_quadrant_row = 1'b0;
      quadrant_msb     = 1'b0;
      mac_en           = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_CLR;
               col_nxt   = '0;
               vec_nxt   = '0;
               pair_nxt  = 2'd0;
               quad_nxt  = 1'b0;
            end
         end

         S_CLR: begin
            busy      = 1'b1;
            ctr_clear = 1'b1;
            state_nxt = S_ROW_A;
         end

         S_ROW_A: begin
            busy         = 1'b1;
            mac_en       = 1'b1;
            quadrant_msb = quad;
            if (col_last) begin
               new_row   = 1'b1;
               col_nxt   = '0;
               state_nxt = S_ROW_B;
            end else begin
               col_nxt = col + 1'b1;
            end
         end

         S_ROW_B: begin
            busy         = 1'b1;
            mac_en       = 1'b1;
            quadrant_msb = quad;
            if (col_last) begin
               col_nxt = '0;
               if (!vec_last) begin
                  new_row   = 1'b1;
                  state_nxt = S_RESTART;
               end else begin
                  // Both strobes together; the counter gives the quadrant
                  // row priority and advances to the next pair.
                  new_quadrant_row = 1'b1;
                  new_vector       = 1'b1;
                  vec_nxt          = '0;
                  if (!pair_last) begin
                     pair_nxt  = pair + 2'd1;
                     state_nxt = S_ROW_A;
                  end else begin
                     // Counter wraps on this strobe; point its reload at the
                     // base of the following quadrant.
                     quadrant_msb = ~quad;
                     if (!quad) begin
                        pair_nxt  = 2'd0;
                        quad_nxt  = 1'b1;
                        state_nxt = S_ROW_A;
                     end else begin
                        state_nxt = S_DONE;
                     end
                  end
               end
            end else begin
               col_nxt = col + 1'b1;
            end
         end

         S_RESTART: begin
            busy         = 1'b1;
            new_vector   = 1'b1;
            quadrant_msb = quad;
            vec_nxt      = vec + 1'b1;
            state_nxt    = S_ROW_A;
         end

         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign ctr_en = busy;

   always_comb begin
      seq_err_nxt = seq_err;
      if (state == S_IDLE && start) begin
         seq_err_nxt = 1'b0;
      end else if (busy) begin
         if ((first_row_a && (row_index != exp_row)) || (new_layer != final_qr)) begin
            seq_err_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - scoreboard bench for layer_sequencer with a behavioural row counter

module tb_layer_sequencer;

   typedef struct {
      int   inst;
      int   done_cyc;
      int   mac;
      int   nr;
      int   nvo;
      int   nqr;
      int   nl;
      int   busyc;
      logic err;
   } exp_t;

   logic       clock = 1'b0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         excl_err = 0;
   exp_t       sb[$];

   logic       clear_s [2];
   logic       start_s [2];
   logic [3:0] row_idx_s [2];
   logic       nl_s [2];
   logic       ctr_en_s [2];
   logic       ctr_clear_s [2];
   logic       new_row_s [2];
   logic       new_vector_s [2];
   logic       nqr_s [2];
   logic       qmsb_s [2];
   logic       mac_en_s [2];
   logic       busy_s [2];
   logic       done_s [2];
   logic       seq_err_s [2];

   logic [3:0] m_idx [2];
   logic       force_en [2];
   logic [3:0] force_val;
   logic       spur [2];

   int acc_mac [2];
   int acc_nr [2];
   int acc_nvo [2];
   int acc_nqr [2];
   int acc_nl [2];
   int acc_busy [2];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Instance 0: COLS=4, VECTORS=3. Instance 1: COLS=1, VECTORS=1.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      layer_sequencer #(
         .COLS    (g == 0 ? 4 : 1),
         .VECTORS (g == 0 ? 3 : 1)
      ) u_dut (
         .clock            (clock),
         .clear            (clear_s[g]),
         .start            (start_s[g]),
         .row_index        (row_idx_s[g]),
         .new_layer        (nl_s[g]),
         .ctr_en           (ctr_en_s[g]),
         .ctr_clear        (ctr_clear_s[g]),
         .new_row          (new_row_s[g]),
         .new_vector       (new_vector_s[g]),
         .new_quadrant_row (nqr_s[g]),
         .quadrant_msb     (qmsb_s[g]),
         .mac_en           (mac_en_s[g]),
         .busy             (busy_s[g]),
         .done             (done_s[g]),
         .seq_err          (seq_err_s[g])
      );

      assign row_idx_s[g] = force_en[g] ? force_val : m_idx[g];
      assign nl_s[g] = (nqr_s[g] && (m_idx[g] == 4'd5 || m_idx[g] == 4'd11)) || spur[g];

      // Row-index counter model: clear loads the quadrant base, new_row +1,
      // new_vector alone -2, new_quadrant_row +1 or wrap to the quadrant base.
      always @(posedge clock) begin
         if (clear_s[g]) begin
            m_idx[g] <= 4'd0;
         end else if (ctr_clear_s[g]) begin
            m_idx[g] <= qmsb_s[g] ? 4'd6 : 4'd0;
         end else if (ctr_en_s[g]) begin
            if (nqr_s[g]) begin
               if (m_idx[g] == 4'd5 || m_idx[g] == 4'd11)
                  m_idx[g] <= qmsb_s[g] ? 4'd6 : 4'd0;
               else
                  m_idx[g] <= m_idx[g] + 4'd1;
            end else if (new_vector_s[g]) begin
               m_idx[g] <= m_idx[g] - 4'd2;
            end else if (new_row_s[g]) begin
               m_idx[g] <= m_idx[g] + 4'd1;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic logic [9:0] outs(input int g);
      return {ctr_en_s[g], ctr_clear_s[g], new_row_s[g], new_vector_s[g], nqr_s[g],
              qmsb_s[g], mac_en_s[g], busy_s[g], done_s[g], seq_err_s[g]};
   endfunction

   // Hand-computed per-pass expectations.
   //   inst 0 (C=4,V=3): 6*(24+2)=156 cycles, mac 144, new_row 30, nv-only 12
   //   inst 1 (C=1,V=1): 6*2=12 cycles,       mac 12,  new_row 6,  nv-only 0
   function automatic exp_t mk(input int g, input int t, input logic err, input int nl);
      exp_t e;
      e.inst     = g;
      e.done_cyc = (g == 0) ? t + 157 : t + 13;
      e.mac      = (g == 0) ? 144 : 12;
      e.nr       = (g == 0) ? 30 : 6;
      e.nvo      = (g == 0) ? 12 : 0;
      e.nqr      = 6;
      e.nl       = nl;
      e.busyc    = (g == 0) ? 157 : 13;
      e.err      = err;
      return e;
   endfunction

   task automatic start_pass(input int g, input bit push, input logic err, input int nl);
      int t;
      start_s[g] = 1'b1;
      t = cyc + 1;
      if (push) sb.push_back(mk(g, t, err, nl));
      step(1);
      start_s[g] = 1'b0;
      chk("start_ctr_clear", ctr_clear_s[g], 1);
      chk("start_seq_err_cleared", seq_err_s[g], 0);
   endtask

   // Monitor: accumulate per-pass activity, compare against the scoreboard on done.
   always @(negedge clock) begin
      for (int g = 0; g < 2; g++) begin
         if (clear_s[g]) begin
            acc_mac[g] = 0; acc_nr[g] = 0; acc_nvo[g] = 0;
            acc_nqr[g] = 0; acc_nl[g] = 0; acc_busy[g] = 0;
         end else begin
            if (busy_s[g]) begin
               acc_busy[g] += 1;
               if (mac_en_s[g]) acc_mac[g] += 1;
               if (new_row_s[g]) acc_nr[g] += 1;
               if (new_vector_s[g] && !nqr_s[g]) acc_nvo[g] += 1;
               if (nqr_s[g]) acc_nqr[g] += 1;
               if (nl_s[g]) acc_nl[g] += 1;
            end
            if ((32'(ctr_clear_s[g]) + 32'(new_row_s[g]) + 32'(new_vector_s[g]) + 32'(nqr_s[g])) > 1 &&
                !(new_vector_s[g] && nqr_s[g] && !new_row_s[g] && !ctr_clear_s[g]))
               excl_err++;
            if (done_s[g]) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_done: inst %0d pulsed done at cycle %0d, none expected", g, cyc);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("done_inst", g, e.inst);
                  chk("done_cycle", cyc, e.done_cyc);
                  chk("mac_count", acc_mac[g], e.mac);
                  chk("new_row_count", acc_nr[g], e.nr);
                  chk("new_vector_only_count", acc_nvo[g], e.nvo);
                  chk("new_quadrant_row_count", acc_nqr[g], e.nqr);
                  chk("new_layer_count", acc_nl[g], e.nl);
                  chk("busy_count", acc_busy[g], e.busyc);
                  chk("seq_err_at_done", seq_err_s[g], e.err);
               end
               acc_mac[g] = 0; acc_nr[g] = 0; acc_nvo[g] = 0;
               acc_nqr[g] = 0; acc_nl[g] = 0; acc_busy[g] = 0;
            end
         end
      end
   end

   initial begin
      int t;
      for (int g = 0; g < 2; g++) begin
         clear_s[g] = 1'b1; start_s[g] = 1'b0; force_en[g] = 1'b0; spur[g] = 1'b0;
         acc_mac[g] = 0; acc_nr[g] = 0; acc_nvo[g] = 0;
         acc_nqr[g] = 0; acc_nl[g] = 0; acc_busy[g] = 0;
      end
      force_val = 4'd3;
      step(3);
      chk("reset_outs_inst0", 32'(outs(0)), 0);
      chk("reset_outs_inst1", 32'(outs(1)), 0);
      clear_s[0] = 1'b0;
      clear_s[1] = 1'b0;
      step(2);

      // Clean default pass.
      start_pass(0, 1, 1'b0, 2);
      step(159);

      // COLS=1, VECTORS=1 pass.
      start_pass(1, 1, 1'b0, 2);
      step(15);

      // Abort in a quadrant-1 ROW_B cycle, then a clean pass.
      start_pass(0, 0, 1'b0, 2);
      step(84);
      chk("pre_abort_busy", busy_s[0], 1);
      chk("pre_abort_quadrant_msb", qmsb_s[0], 1);
      clear_s[0] = 1'b1;
      step(1);
      chk("abort_outs", 32'(outs(0)), 0);
      clear_s[0] = 1'b0;
      step(1);
      chk("abort_stays_idle", busy_s[0], 0);
      start_pass(0, 1, 1'b0, 2);
      step(159);

      // start held across a pass: exactly one restart at t+159.
      start_s[0] = 1'b1;
      t = cyc + 1;
      sb.push_back(mk(0, t, 1'b0, 2));
      sb.push_back(mk(0, t + 159, 1'b0, 2));
      step(160);
      chk("held_start_second_clr", ctr_clear_s[0], 1);
      start_s[0] = 1'b0;
      step(159);

      // Wrong row_index in the first ROW_A cycle of pair 1.
      start_pass(0, 1, 1'b1, 2);
      step(27);
      chk("pre_force_seq_err", seq_err_s[0], 0);
      force_en[0] = 1'b1;
      step(1);
      force_en[0] = 1'b0;
      chk("force_seq_err_set", seq_err_s[0], 1);
      step(131);

      // Spurious new_layer in ROW_A; the start also clears the previous error.
      start_pass(0, 1, 1'b1, 3);
      step(2);
      spur[0] = 1'b1;
      step(1);
      spur[0] = 1'b0;
      chk("spurious_seq_err_set", seq_err_s[0], 1);
      step(157);

      // Clean pass after an error.
      start_pass(0, 1, 1'b0, 2);
      step(160);

      chk("scoreboard_drained", sb.size(), 0);
      chk("strobe_exclusivity", excl_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
